// File: rtl/branch_pkg.sv
// Shared types for the branch resolution unit.
// Holds the branch condition codes and the instruction size.
package branch_pkg;

    typedef enum logic [2:0] {
        BR_EQ   = 3'b000,
        BR_NE   = 3'b001,
        BR_NONE = 3'b010,
        BR_JUMP = 3'b011,
        BR_LT   = 3'b100,
        BR_GE   = 3'b101,
        BR_LTU  = 3'b110,
        BR_GEU  = 3'b111
    } br_type_e;

    localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/branch_cmp.sv
// Combinational branch condition evaluator.
// Ports: rs1/rs2 operands, br_type condition code, taken result.
module branch_cmp
    import branch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  br_type_e        br_type,
    output logic            taken
);

    always_comb begin
        taken = 1'b0;
        unique case (br_type)
            BR_EQ:   taken = (rs1 == rs2);
            BR_NE:   taken = (rs1 != rs2);
            BR_NONE: taken = 1'b0;
            BR_JUMP: taken = 1'b1;
            BR_LT:   taken = ($signed(rs1) <  $signed(rs2));
            BR_GE:   taken = ($signed(rs1) >= $signed(rs2));
            BR_LTU:  taken = (rs1 <  rs2);
            BR_GEU:  taken = (rs1 >= rs2);
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Two-stage branch resolution: S1 registers the request, S2 registers
// direction, target, mispredict and redirect. Valid/ready on both sides,
// flush squashes in-flight entries, saturating branch/mispredict counters.
// Ports: clk, rst (sync high), flush, clr_stats, in_* request handshake,
// out_* result handshake, branch_count, mispredict_count.
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             clr_stats,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [XLEN-1:0]  in_offset,
    input  logic [2:0]       in_br_type,
    input  logic             in_pred_taken,
    input  logic [XLEN-1:0]  in_pred_target,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_taken,
    output logic [XLEN-1:0]  out_target,
    output logic             out_mispredict,
    output logic [XLEN-1:0]  out_redirect_pc,
    output logic             out_misaligned,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);

    logic            s1_valid;
    logic [XLEN-1:0] s1_pc;
    logic [XLEN-1:0] s1_rs1;
    logic [XLEN-1:0] s1_rs2;
    logic [XLEN-1:0] s1_offset;
    br_type_e        s1_br_type;
    logic            s1_pred_taken;
    logic [XLEN-1:0] s1_pred_target;

    logic            out_is_branch;

    logic            s2_accept;
    logic            s1_load;
    logic            s2_load;
    logic            out_fire;

    logic            cmp_taken;
    logic [XLEN-1:0] nx_target;
    logic [XLEN-1:0] nx_fall;
    logic            nx_mispredict;
    logic            nx_misaligned;

    assign s2_accept = !out_valid || out_ready;
    assign in_ready  = !s1_valid || s2_accept;
    assign s1_load   = in_valid && in_ready;
    assign s2_load   = s1_valid && s2_accept;
    assign out_fire  = out_valid && out_ready;

    branch_cmp #(
        .XLEN(XLEN)
    ) u_cmp (
        .rs1    (s1_rs1),
        .rs2    (s1_rs2),
        .br_type(s1_br_type),
        .taken  (cmp_taken)
    );

    assign nx_target     = s1_pc + s1_offset;
    assign nx_fall       = s1_pc + XLEN'(INSTR_BYTES);
    assign nx_misaligned = cmp_taken && (nx_target[1:0] != 2'b00);

    // Direction wrong, or both taken but fetch went to the wrong place.
    assign nx_mispredict = (cmp_taken != s1_pred_taken) ||
                           (cmp_taken && s1_pred_taken &&
                            (nx_target != s1_pred_target));

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
        end else if (flush) begin
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
            end
            if (s2_accept) begin
                out_valid <= s1_valid;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (s1_load) begin
            s1_pc          <= in_pc;
            s1_rs1         <= in_rs1;
            s1_rs2         <= in_rs2;
            s1_offset      <= in_offset;
            s1_br_type     <= br_type_e'(in_br_type);
            s1_pred_taken  <= in_pred_taken;
            s1_pred_target <= in_pred_target;
        end
    end

    // Output data only moves when S2 takes a new entry, so it is held
    // stable while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_taken       <= 1'b0;
            out_target      <= '0;
            out_mispredict  <= 1'b0;
            out_redirect_pc <= '0;
            out_misaligned  <= 1'b0;
            out_is_branch   <= 1'b0;
        end else if (s2_load) begin
            out_taken       <= cmp_taken;
            out_target      <= nx_target;
            out_mispredict  <= nx_mispredict;
            out_redirect_pc <= cmp_taken ? nx_target : nx_fall;
            out_misaligned  <= nx_misaligned;
            out_is_branch   <= (s1_br_type != BR_NONE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr_stats) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else if (out_fire) begin
            if (out_is_branch && (branch_count != '1)) begin
                branch_count <= branch_count + CNT_W'(1);
            end
            if (out_mispredict && (mispredict_count != '1)) begin
                mispredict_count <= mispredict_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed cases plus random traffic
// checked against a transaction-level queue model.
module tb_branch_resolve_unit;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;
    localparam int CMAX  = 15;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] off;
        logic [2:0]  bt;
        logic        pt;
        logic [31:0] ptgt;
    } req_t;

    typedef struct packed {
        logic        taken;
        logic [31:0] target;
        logic        misp;
        logic [31:0] redir;
        logic        misal;
        logic        is_br;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             clr_stats;
    logic             in_valid;
    logic             in_ready;
    logic [XLEN-1:0]  in_pc;
    logic [XLEN-1:0]  in_rs1;
    logic [XLEN-1:0]  in_rs2;
    logic [XLEN-1:0]  in_offset;
    logic [2:0]       in_br_type;
    logic             in_pred_taken;
    logic [XLEN-1:0]  in_pred_target;
    logic             out_valid;
    logic             out_ready;
    logic             out_taken;
    logic [XLEN-1:0]  out_target;
    logic             out_mispredict;
    logic [XLEN-1:0]  out_redirect_pc;
    logic             out_misaligned;
    logic [CNT_W-1:0] branch_count;
    logic [CNT_W-1:0] mispredict_count;

    int checks   = 0;
    int failures = 0;
    int n_in     = 0;
    int n_out    = 0;
    int m_br     = 0;
    int m_mp     = 0;

    req_t pend[$];
    exp_t q[$];

    branch_resolve_unit #(
        .XLEN (XLEN),
        .CNT_W(CNT_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .clr_stats       (clr_stats),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_pc           (in_pc),
        .in_rs1          (in_rs1),
        .in_rs2          (in_rs2),
        .in_offset       (in_offset),
        .in_br_type      (in_br_type),
        .in_pred_taken   (in_pred_taken),
        .in_pred_target  (in_pred_target),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_taken       (out_taken),
        .out_target      (out_target),
        .out_mispredict  (out_mispredict),
        .out_redirect_pc (out_redirect_pc),
        .out_misaligned  (out_misaligned),
        .branch_count    (branch_count),
        .mispredict_count(mispredict_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input req_t r);
        exp_t e;
        logic t;
        logic [31:0] fall;
        case (r.bt)
            3'd0:    t = (r.rs1 == r.rs2);
            3'd1:    t = (r.rs1 != r.rs2);
            3'd2:    t = 1'b0;
            3'd3:    t = 1'b1;
            3'd4:    t = ($signed(r.rs1) < $signed(r.rs2));
            3'd5:    t = !($signed(r.rs1) < $signed(r.rs2));
            3'd6:    t = (r.rs1 < r.rs2);
            default: t = !(r.rs1 < r.rs2);
        endcase
        e.taken  = t;
        e.target = r.pc + r.off;
        fall     = r.pc + 32'd4;
        e.misp   = (t != r.pt) || (t && r.pt && (e.target != r.ptgt));
        e.redir  = t ? e.target : fall;
        e.misal  = t && (e.target % 4 != 0);
        e.is_br  = (r.bt != 3'd2);
        return e;
    endfunction

    // One clock: drive from pend, observe handshakes, advance the model.
    task automatic tick();
        exp_t e;
        logic in_hs;
        logic out_hs;
        if (pend.size() > 0) begin
            in_valid       = 1'b1;
            in_pc          = pend[0].pc;
            in_rs1         = pend[0].rs1;
            in_rs2         = pend[0].rs2;
            in_offset      = pend[0].off;
            in_br_type     = pend[0].bt;
            in_pred_taken  = pend[0].pt;
            in_pred_target = pend[0].ptgt;
        end else begin
            in_valid = 1'b0;
        end
        #1;
        in_hs  = (in_valid === 1'b1) && (in_ready === 1'b1);
        out_hs = (out_valid === 1'b1) && (out_ready === 1'b1);
        if (out_valid === 1'b1 && rst !== 1'b1) begin
            if (q.size() == 0) begin
                chk("spurious_out", out_valid, 0);
            end else begin
                e = q[0];
                chk("taken", out_taken, e.taken);
                chk("target", out_target, e.target);
                chk("mispredict", out_mispredict, e.misp);
                chk("misaligned", out_misaligned, e.misal);
                if (e.misp) chk("redirect", out_redirect_pc, e.redir);
            end
        end
        if (out_hs && q.size() > 0) begin
            e = q.pop_front();
            n_out++;
            if (e.is_br && m_br < CMAX) m_br++;
            if (e.misp && m_mp < CMAX) m_mp++;
        end
        if (in_hs) begin
            q.push_back(model(pend[0]));
            void'(pend.pop_front());
            n_in++;
        end
        if (flush) q.delete();
        if (clr_stats) begin
            m_br = 0;
            m_mp = 0;
        end
        if (rst) begin
            q.delete();
            m_br = 0;
            m_mp = 0;
        end
        @(posedge clk);
        #1;
        chk("branch_count", branch_count, m_br);
        chk("mispredict_count", mispredict_count, m_mp);
    endtask

    task automatic wait_out(input int max);
        int n = 0;
        while (out_valid !== 1'b1 && n < max) begin
            tick();
            n++;
        end
        chk("wait_out_valid", out_valid, 1);
    endtask

    task automatic run(input req_t r);
        pend.push_back(r);
        tick();
        wait_out(6);
    endtask

    task automatic drain(input int max);
        int n = 0;
        while ((pend.size() > 0 || q.size() > 0) && n < max) begin
            tick();
            n++;
        end
        chk("drain_empty", q.size() + pend.size(), 0);
    endtask

    function automatic req_t rnd_req();
        req_t r;
        r.pc   = $urandom;
        r.rs1  = $urandom;
        case ($urandom % 4)
            0:       r.rs2 = r.rs1;
            1:       r.rs2 = r.rs1 ^ 32'h8000_0000;
            default: r.rs2 = $urandom;
        endcase
        r.off  = ($urandom % 2) ? 32'($urandom_range(0, 8191)) - 32'd4096
                                : $urandom;
        r.bt   = 3'($urandom % 8);
        r.pt   = 1'($urandom % 2);
        r.ptgt = ($urandom % 2) ? r.pc + r.off : $urandom;
        return r;
    endfunction

    initial begin
        int base_in;
        int base_out;
        int br0;
        logic [31:0] hold_tgt;
        rst            = 1'b1;
        flush          = 1'b0;
        clr_stats      = 1'b0;
        in_valid       = 1'b0;
        out_ready      = 1'b1;
        in_pc          = '0;
        in_rs1         = '0;
        in_rs2         = '0;
        in_offset      = '0;
        in_br_type     = '0;
        in_pred_taken  = 1'b0;
        in_pred_target = '0;

        tick();
        tick();
        rst = 1'b0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_taken", out_taken, 0);
        chk("rst_out_target", out_target, 0);
        chk("rst_out_misp", out_mispredict, 0);
        chk("rst_out_redir", out_redirect_pc, 0);
        chk("rst_out_misal", out_misaligned, 0);

        // BLT signed, latency two cycles
        pend.push_back('{pc: 32'h100, rs1: 32'hFFFF_FFFF, rs2: 32'd1,
                         off: 32'h20, bt: 3'd4, pt: 1'b0, ptgt: 32'h0});
        tick();
        chk("lat_s1", out_valid, 0);
        tick();
        chk("lat_s2", out_valid, 1);
        chk("blt_taken", out_taken, 1);
        chk("blt_target", out_target, 32'h120);
        chk("blt_misp", out_mispredict, 1);
        chk("blt_redir", out_redirect_pc, 32'h120);

        run('{pc: 32'h100, rs1: 32'hFFFF_FFFF, rs2: 32'd1,
              off: 32'h20, bt: 3'd6, pt: 1'b0, ptgt: 32'h0});
        chk("bltu_taken", out_taken, 0);
        chk("bltu_misp", out_mispredict, 0);

        run('{pc: 32'h100, rs1: 32'd5, rs2: 32'd5,
              off: 32'h20, bt: 3'd0, pt: 1'b1, ptgt: 32'h124});
        chk("beq_taken", out_taken, 1);
        chk("beq_misp", out_mispredict, 1);
        chk("beq_redir", out_redirect_pc, 32'h120);

        run('{pc: 32'h200, rs1: 32'd5, rs2: 32'd5,
              off: 32'h40, bt: 3'd2, pt: 1'b1, ptgt: 32'h240});
        chk("none_taken", out_taken, 0);
        chk("none_misp", out_mispredict, 1);
        chk("none_redir", out_redirect_pc, 32'h204);

        run('{pc: 32'hFFFF_FFFC, rs1: 32'd0, rs2: 32'd0,
              off: 32'd8, bt: 3'd3, pt: 1'b1, ptgt: 32'h4});
        chk("wrap_taken", out_taken, 1);
        chk("wrap_target", out_target, 32'h4);
        chk("wrap_misal", out_misaligned, 0);

        run('{pc: 32'hFFFF_FFFC, rs1: 32'd0, rs2: 32'd0,
              off: 32'd6, bt: 3'd3, pt: 1'b1, ptgt: 32'h2});
        chk("misal_flag", out_misaligned, 1);
        chk("misal_no_misp", out_mispredict, 0);
        tick();
        drain(10);

        // Backpressure: four back-to-back, consumer stalls
        out_ready = 1'b0;
        base_in   = n_in;
        base_out  = n_out;
        for (int i = 0; i < 4; i++) begin
            pend.push_back('{pc: 32'h1000 + 32'(i * 16), rs1: 32'(i),
                             rs2: 32'd2, off: 32'h80, bt: 3'd4,
                             pt: 1'b0, ptgt: 32'h0});
        end
        tick();
        tick();
        chk("bp_accepts", n_in - base_in, 2);
        chk("bp_in_ready", in_ready, 0);
        hold_tgt = 32'h1080;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_target", out_target, hold_tgt);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 20 && (n_out - base_out) < 4; i++) tick();
        chk("bp_emitted", n_out - base_out, 4);

        // Flush with two in flight and an input offered
        out_ready = 1'b0;
        base_out  = n_out;
        br0       = m_br;
        for (int i = 0; i < 3; i++) begin
            pend.push_back('{pc: 32'h3000, rs1: 32'd1, rs2: 32'd1,
                             off: 32'h10, bt: 3'd0, pt: 1'b1,
                             ptgt: 32'h3010});
        end
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        pend.delete();
        chk("flush_valid", out_valid, 0);
        out_ready = 1'b1;
        pend.push_back('{pc: 32'h3100, rs1: 32'd1, rs2: 32'd2,
                         off: 32'h10, bt: 3'd1, pt: 1'b0, ptgt: 32'h0});
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("flush_quiet", out_valid, 0);
        end
        chk("flush_emitted", n_out - base_out, 0);
        chk("flush_brcount", branch_count, br0);

        // Saturation then clear
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        for (int i = 0; i < 20; i++) begin
            pend.push_back('{pc: 32'h4000 + 32'(i * 4), rs1: 32'd1,
                             rs2: 32'd2, off: 32'h40, bt: 3'd0,
                             pt: 1'b1, ptgt: 32'h0});
        end
        drain(60);
        chk("sat_br", branch_count, CMAX);
        chk("sat_mp", mispredict_count, CMAX);
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        chk("clr_br", branch_count, 0);
        chk("clr_mp", mispredict_count, 0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            if (pend.size() < 3 && ($urandom % 3) != 0) pend.push_back(rnd_req());
            out_ready = ($urandom % 4) != 0;
            flush     = ($urandom % 40) == 0;
            clr_stats = ($urandom % 60) == 0;
            tick();
        end
        flush     = 1'b0;
        clr_stats = 1'b0;
        out_ready = 1'b1;
        drain(40);

        // Reset mid-stream
        for (int i = 0; i < 6; i++) begin
            pend.push_back('{pc: 32'h5000, rs1: 32'd0, rs2: 32'd9,
                             off: 32'h8, bt: 3'd0, pt: 1'b1, ptgt: 32'h0});
        end
        tick();
        tick();
        tick();
        out_ready = 1'b0;
        tick();
        pend.delete();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_br", branch_count, 0);
        chk("mid_rst_mp", mispredict_count, 0);
        chk("mid_rst_ready", in_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Parametrised, pipelined branch resolution unit for the pipelined core. It evaluates the branch condition and computes the branch target. It compares the outcome against the fetch-stage prediction and flags mispredictions with a redirect PC. A valid/ready handshake on both sides, a flush input and saturating branch and mispredict statistics counters make it a drop-in execute-stage block.

## Interface
- XLEN, 32, operand/PC width (≥ 8)
- CNT_W, 16, statistics counter width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  squash all in-flight entries
- clr_stats  in  1  zero both statistics counters
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept
- in_pc  in  XLEN  branch instruction PC
- in_rs1, in_rs2  in  XLEN  compare operands
- in_offset  in  XLEN  sign-extended immediate
- in_br_type  in  3  condition code (br_type_e)
- in_pred_taken  in  1  fetch prediction
- in_pred_target  in  XLEN  predicted target
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts
- out_taken  out  1  resolved direction
- out_target  out  XLEN  in_pc + in_offset
- out_mispredict  out  1  redirect required
- out_redirect_pc  out  XLEN  correct next PC
- out_misaligned  out  1  taken target with bits [1:0] ≠ 0
- branch_count, mispredict_count  out  CNT_W  saturating statistics

## Operation
- br_type codes: 000 EQ, 001 NE, 010 NONE, 011 JUMP (always taken), 100 LT, 101 GE, 110 LTU, 111 GEU.
- LT/GE use signed compare. LTU/GEU use unsigned. NONE is never taken.
- Target = in_pc + in_offset, truncated mod 2^XLEN. Fall-through = in_pc + 4, mod 2^XLEN.
- out_mispredict = (taken ≠ pred_taken) | (taken & pred_taken & target ≠ pred_target).
- out_redirect_pc = taken ? target : fall-through. It is meaningful only when out_mispredict is high.
- out_misaligned = taken & (target[1:0] ≠ 0). It does not affect mispredict.
- Pipeline stage S1 registers the inputs. Stage S2 registers the compare, target and mispredict results.
- Each stage advances when it is empty or the stage downstream accepts.
- in_ready = !S1.valid | S2 accepts. S2 accepts = !S2.valid | out_ready.
- Counters update on an output handshake (out_valid & out_ready):
  - branch_count += 1 if br_type ≠ NONE.
  - mispredict_count += 1 if out_mispredict.
  - Both saturate at 2^CNT_W−1.
- clr_stats zeroes both counters. If clr_stats coincides with an output handshake, the counters still read zero.

## Timing
- Latency: input handshake in cycle t gives out_valid in cycle t+2 when there is no backpressure. Throughput is 1/cycle.
- Reset values: out_valid=0, all out_* data=0, counters=0. in_ready=1 from the first cycle after reset.
- Backpressure: while out_valid & !out_ready, all out_* data hold stable. S1 fills, then in_ready drops. Nothing is lost or duplicated.
- flush clears both stage valids at the next edge.
  - An input handshake in the flush cycle is discarded.
  - An output handshake in the flush cycle completes and is counted.
  - in_ready is unaffected by flush.
- rst has priority over flush and clr_stats. rst asserted mid-stream drops all entries.
- Data registers need no reset except the out_* registers, which reset to 0.

## Structure
- Shared package branch_pkg holds:
  - br_type_e enum with the codes above.
  - INSTR_BYTES = 4.
- Sub-module branch_cmp: combinational, parameter XLEN. Inputs are rs1, rs2 and br_type; output is taken. It is instantiated in S2.
- Pipeline registers and counters live in branch_resolve_unit.

## Test plan
- BLT, rs1=0xFFFF_FFFF, rs2=1, pc=0x100, off=0x20, pred not taken → taken=1, target=0x120, mispredict=1, redirect=0x120. BLTU with the same operands → taken=0, mispredict=0.
- BEQ equal operands, pred taken with pred_target=0x124 but real target 0x120 → mispredict=1, redirect=0x120. Then NONE with pred taken → mispredict=1, redirect=pc+4.
- pc=0xFFFF_FFFC, JUMP, off=8 → target=0x4 (wrap), taken=1. off=6 → out_misaligned=1.
- Stream 4 back-to-back requests, hold out_ready=0 for 3 cycles → in_ready drops after 2 accepts. Outputs stay stable. All 4 results are emitted in order, with no loss.
- flush with 2 entries in flight and a simultaneous input → out_valid=0 the next cycle, 0 results emitted, branch_count unchanged.
- CNT_W=4: 20 mispredicting branches → both counters stick at 15. clr_stats → 0. rst mid-stream → out_valid=0 and counters=0 in the following cycle.
